// File: rtl/chaotic_ks_pkg.sv
// Shared types and the discretised logistic-map update for the chaotic keystream generator.
// map_step works on up to MAX_W bits; callers pass their channel width w.
package chaotic_ks_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned MAX_W   = 64;
  localparam int unsigned PROD_W  = 2 * MAX_W + 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } ks_state_e;

  // x' = ((4 * x * ~x) >> w)[w-1:0] ^ k, everything confined to the low w bits
  function automatic logic [MAX_W-1:0] map_step(input logic [MAX_W-1:0] x,
                                                input logic [MAX_W-1:0] k,
                                                input int unsigned      w);
    logic [MAX_W-1:0]  mask;
    logic [PROD_W-1:0] prod;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    prod = (PROD_W'(x & mask) * PROD_W'(~x & mask)) << 2;
    return (MAX_W'(prod >> w) ^ k) & mask;
  endfunction

endpackage

// File: rtl/chaotic_map_cell.sv
// One chaotic channel: a W-bit state register that is seeded on load and
// advanced by map_step on step. Exposes the next-state value for the output XOR.
module chaotic_map_cell
  import chaotic_ks_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  input  logic [W-1:0] k,
  output logic [W-1:0] x_nxt_c
);

  logic [W-1:0] x;

  always_comb begin
    x_nxt_c = x;
    if (load) begin
      x_nxt_c = seed;
    end else if (step) begin
      x_nxt_c = W'(map_step(MAX_W'(x), MAX_W'(k), W));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
    end else begin
      x <= x_nxt_c;
    end
  end

endmodule

// File: rtl/chaotic_keystream_gen.sv
// Parametrised chaotic-map keystream generator: NMAPS logistic-map channels, WARMUP
// discarded iterations, one word per valid/ready handshake. CHAOTIC_KS_XOR_EN adds pt_data/ct_data.
module chaotic_keystream_gen
  import chaotic_ks_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned NMAPS  = 2,
  parameter int unsigned WARMUP = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NMAPS*W-1:0] key,
  input  logic [W-1:0]       iv,
  input  logic               ks_ready,
  output logic               ks_valid,
  output logic [W-1:0]       keystream,
  output logic               busy
`ifdef CHAOTIC_KS_XOR_EN
  ,
  input  logic [W-1:0]       pt_data,
  output logic [W-1:0]       ct_data
`endif
);

  localparam int unsigned CNT_W     = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);
  localparam int unsigned WARM_LAST = (WARMUP == 0) ? 0 : WARMUP - 1;

  ks_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [NMAPS*W-1:0] key_q;
  logic [W-1:0]       iv_q;
  logic               load_c;
  logic               step_c;
  logic [W-1:0]       x_nxt [NMAPS];
  logic [W-1:0]       ks_nxt_c;

  // Next-state and channel control; start from any state restarts seeding.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_c    = 1'b1;
        state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
      end
      ST_WARMUP: begin
        step_c = 1'b1;
        if (cnt == CNT_W'(WARM_LAST)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        step_c = ks_valid & ks_ready;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Warm-up iteration counter, saturating at WARMUP.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == ST_LOAD) begin
      cnt <= '0;
    end else if ((state == ST_WARMUP) && (cnt != CNT_W'(WARMUP))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q <= '0;
      iv_q  <= '0;
    end else if (start) begin
      key_q <= key;
      iv_q  <= iv;
    end
  end

  for (genvar i = 0; i < NMAPS; i++) begin : g_cell
    chaotic_map_cell #(.W(W)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .load    (load_c),
      .step    (step_c),
      .seed    (key_q[i*W +: W] ^ iv_q ^ W'(i)),
      .k       (key_q[i*W +: W]),
      .x_nxt_c (x_nxt[i])
    );
  end

  always_comb begin
    ks_nxt_c = '0;
    for (int unsigned m = 0; m < NMAPS; m++) begin
      ks_nxt_c = ks_nxt_c ^ x_nxt[m];
    end
  end

  // Outputs track the state being entered so they line up with the channel registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ks_valid  <= 1'b0;
      keystream <= '0;
      busy      <= 1'b0;
    end else begin
      ks_valid  <= (state_nxt == ST_RUN);
      keystream <= (state_nxt == ST_RUN) ? ks_nxt_c : '0;
      busy      <= (state_nxt == ST_LOAD) || (state_nxt == ST_WARMUP);
    end
  end

`ifdef CHAOTIC_KS_XOR_EN
  assign ct_data = pt_data ^ keystream;
`endif

endmodule

// File: tb/tb_chaotic_keystream_gen.sv
// Bench for chaotic_keystream_gen: three instances (W8/WARMUP0, W8/WARMUP4, defaults)
// checked every cycle against a countdown-based behavioural model plus literal vectors.
module tb_chaotic_keystream_gen;
  import chaotic_ks_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        st    [3];
  logic        rdy   [3];
  logic [63:0] key_v [3];
  logic [31:0] iv_v  [3];
  logic        vld   [3];
  logic        bsy   [3];
  logic [7:0]  ks0, ks1;
  logic [31:0] ks2;
`ifdef CHAOTIC_KS_XOR_EN
  logic [7:0]  pt0, pt1, ct0, ct1;
  logic [31:0] pt2, ct2;
`endif

  int pw  [3] = '{8, 8, 32};
  int pn  [3] = '{1, 1, 2};
  int pwu [3] = '{0, 4, 8};

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  chaotic_keystream_gen #(.W(8), .NMAPS(1), .WARMUP(0)) dut0 (
    .clk(clk), .reset(reset), .start(st[0]), .key(key_v[0][7:0]), .iv(iv_v[0][7:0]),
    .ks_ready(rdy[0]), .ks_valid(vld[0]), .keystream(ks0), .busy(bsy[0])
`ifdef CHAOTIC_KS_XOR_EN
    , .pt_data(pt0), .ct_data(ct0)
`endif
  );

  chaotic_keystream_gen #(.W(8), .NMAPS(1), .WARMUP(4)) dut1 (
    .clk(clk), .reset(reset), .start(st[1]), .key(key_v[1][7:0]), .iv(iv_v[1][7:0]),
    .ks_ready(rdy[1]), .ks_valid(vld[1]), .keystream(ks1), .busy(bsy[1])
`ifdef CHAOTIC_KS_XOR_EN
    , .pt_data(pt1), .ct_data(ct1)
`endif
  );

  chaotic_keystream_gen dut2 (
    .clk(clk), .reset(reset), .start(st[2]), .key(key_v[2]), .iv(iv_v[2]),
    .ks_ready(rdy[2]), .ks_valid(vld[2]), .keystream(ks2), .busy(bsy[2])
`ifdef CHAOTIC_KS_XOR_EN
    , .pt_data(pt2), .ct_data(ct2)
`endif
  );

  // Model: on start seed and pre-apply all warm-up steps, then count down the latency.
  logic [63:0] mx [3][8];
  logic [63:0] mk [3][8];
  int          m_delay [3] = '{0, 0, 0};
  bit          m_valid [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] get_ks(input int d);
    case (d)
      0:       return 64'(ks0);
      1:       return 64'(ks1);
      default: return 64'(ks2);
    endcase
  endfunction

  function automatic logic [63:0] exp_ks(input int d);
    logic [63:0] r = '0;
    for (int i = 0; i < pn[d]; i++) r = r ^ mx[d][i];
    return r & wmask(pw[d]);
  endfunction

  task automatic step_all(input int d);
    for (int i = 0; i < pn[d]; i++) mx[d][i] = map_step(mx[d][i], mk[d][i], pw[d]);
  endtask

  task automatic model_edge(input int d);
    logic [63:0] m;
    m = wmask(pw[d]);
    if (!reset) begin
      m_valid[d] = 1'b0;
      m_delay[d] = 0;
    end else if (st[d]) begin
      for (int i = 0; i < pn[d]; i++) begin
        mk[d][i] = (key_v[d] >> (i * pw[d])) & m;
        mx[d][i] = (mk[d][i] ^ 64'(iv_v[d]) ^ 64'(i)) & m;
      end
      repeat (pwu[d]) step_all(d);
      m_delay[d] = 1 + pwu[d];
      m_valid[d] = 1'b0;
    end else if (m_delay[d] > 0) begin
      m_delay[d] = m_delay[d] - 1;
      if (m_delay[d] == 0) m_valid[d] = 1'b1;
    end else if (m_valid[d] && rdy[d]) begin
      step_all(d);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) model_edge(d);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("model_valid%0d", d), 64'(vld[d]), 64'(m_valid[d]));
        check($sformatf("model_busy%0d", d), 64'(bsy[d]), 64'(m_delay[d] > 0));
        if (m_valid[d]) check($sformatf("model_ks%0d", d), get_ks(d), exp_ks(d));
      end
`ifdef CHAOTIC_KS_XOR_EN
      if (vld[2]) check("ct_xor", 64'(ct2), 64'(pt2 ^ ks2));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_v0"}, 64'(vld[0]), 64'd0);
    check({tag, "_v2"}, 64'(vld[2]), 64'd0);
    check({tag, "_b1"}, 64'(bsy[1]), 64'd0);
    check({tag, "_b2"}, 64'(bsy[2]), 64'd0);
    check({tag, "_k2"}, 64'(ks2), 64'd0);
  endtask

`ifdef CHAOTIC_KS_XOR_EN
  logic [31:0] ct_log [$];
`endif

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; rdy[d] = 1'b1; key_v[d] = '0; iv_v[d] = '0;
    end
`ifdef CHAOTIC_KS_XOR_EN
    pt0 = '0; pt1 = '0; pt2 = 32'hA5A5A5A5;
`endif
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid%0d", d), 64'(vld[d]), 64'd0);
      check($sformatf("rst_busy%0d", d), 64'(bsy[d]), 64'd0);
      check($sformatf("rst_ks%0d", d), get_ks(d), 64'd0);
    end
    chk_en = 1'b1;
    reset  = 1'b1;
    tick();

    // W8 WARMUP0: key 0, iv 0x80 -> 0x80, 0xFE, 0x03 from cycle t+2
    key_v[0] = 64'h0; iv_v[0] = 32'h80; st[0] = 1'b1;
    tick(); st[0] = 1'b0;
    check("a_t1_valid", 64'(vld[0]), 64'd0);
    check("a_t1_busy", 64'(bsy[0]), 64'd1);
    tick();
    check("a_t2_valid", 64'(vld[0]), 64'd1);
    check("a_w0", 64'(ks0), 64'h80);
    tick();
    check("a_w1", 64'(ks0), 64'hFE);
    tick();
    check("a_w2", 64'(ks0), 64'h03);

    // W8 WARMUP4: busy five cycles, first valid at t+6, all-zero words
    key_v[1] = 64'h0; iv_v[1] = 32'h0; st[1] = 1'b1;
    tick(); st[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check($sformatf("b_busy%0d", j), 64'(bsy[1]), 64'd1);
      check($sformatf("b_nvld%0d", j), 64'(vld[1]), 64'd0);
      tick();
    end
    check("b_first_valid", 64'(vld[1]), 64'd1);
    check("b_busy_off", 64'(bsy[1]), 64'd0);
    check("b_w0", 64'(ks1), 64'h00);
    tick();
    check("b_w1", 64'(ks1), 64'h00);

    // Defaults with random key/iv and random ready
    key_v[2] = {$urandom, $urandom}; iv_v[2] = $urandom; st[2] = 1'b1;
    tick(); st[2] = 1'b0;
    for (int j = 0; j < 200; j++) begin
      rdy[2] = 1'($urandom_range(0, 1));
      tick();
    end

    // Re-key mid-RUN
    rdy[2] = 1'b1;
    check("c_in_run", 64'(vld[2]), 64'd1);
    key_v[2] = {$urandom, $urandom}; iv_v[2] = $urandom; st[2] = 1'b1;
    tick(); st[2] = 1'b0;
    check("restart_drop", 64'(vld[2]), 64'd0);
    repeat (9) tick();
    check("restart_valid", 64'(vld[2]), 64'd1);
    for (int j = 0; j < 40; j++) begin
      rdy[2] = 1'($urandom_range(0, 1));
      tick();
    end

    // Reset during WARMUP, with start asserted alongside
    st[2] = 1'b1; tick(); st[2] = 1'b0;
    tick(); tick();
    check("d_in_warmup", 64'(bsy[2]), 64'd1);
    reset = 1'b0; st[2] = 1'b1; st[0] = 1'b1;
    tick();
    reset = 1'b1; st[2] = 1'b0; st[0] = 1'b0;
    check_all_zero("rst_warm");
    repeat (3) tick();
    check_all_zero("rst_warm_idle");

    // Reset during a RUN stall
    rdy[2] = 1'b0;
    st[2] = 1'b1; tick(); st[2] = 1'b0;
    repeat (10) tick();
    check("e_stall_valid", 64'(vld[2]), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_all_zero("rst_stall");
    rdy[2] = 1'b1;
    tick();
    check_all_zero("rst_stall_idle");

`ifdef CHAOTIC_KS_XOR_EN
    key_v[2] = 64'h0123456789ABCDEF; iv_v[2] = 32'h0BADF00D; pt2 = 32'hA5A5A5A5;
    st[2] = 1'b1; tick(); st[2] = 1'b0;
    repeat (9) tick();
    for (int j = 0; j < 8; j++) begin
      check("x_enc_valid", 64'(vld[2]), 64'd1);
      ct_log.push_back(ct2);
      tick();
    end
    st[2] = 1'b1; tick(); st[2] = 1'b0;
    repeat (9) tick();
    for (int j = 0; j < 8; j++) begin
      pt2 = ct_log[j];
      #1;
      check("x_dec", 64'(ct2), 64'hA5A5A5A5);
      tick();
    end
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
